// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver (2-FF synced input, mid-bit sampling) feeding a FWFT byte FIFO.
// Latency: pin falling edge to rx_valid is 3 + CPB/2 + 9*CPB + 1 cycles when the FIFO is empty.
// Backpressure: valid/ready pop; a good byte arriving while full with no pop is dropped with an overflow pulse.
// Ports: clock/reset_n (async active-low); uart_rx_pin raw serial input (idle high);
//        rx_data/rx_valid/rx_ready head-of-FIFO handshake; frame_error/overflow one-cycle pulses.
module uart_rx_fifo #(
  parameter int UART_CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overflow
);

  localparam int CW = $clog2(UART_CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(UART_CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(UART_CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Input synchronizer and receive FSM state
  logic          sync1_q, rx_s_q;
  logic [1:0]    settle_q;
  logic          armed_q, armed_d;
  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_done, stop_bad;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push, pop, drop;
  logic          frame_error_q, overflow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= uart_rx_pin;
      rx_s_q    <= sync1_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q && armed_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;  // start bit gone by mid-bit: treat as a glitch
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit leaves half a bit of margin for the next start edge.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (rx_s_q) byte_done = 1'b1;
          else        stop_bad  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The synchronizer holds its reset value (high) for two cycles after release; settle_q
  // keeps that fake idle level from arming, so a line held low across reset never starts a frame.
  always_comb begin
    armed_d = armed_q;
    if (rx_s_q && settle_q[1]) armed_d = 1'b1;
    if (stop_bad)              armed_d = 1'b0;
  end

  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign push     = byte_done && ((count_q != FULL_CNT) || pop);
  assign drop     = byte_done && (count_q == FULL_CNT) && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (pop && !push) count_d = count_q - (PW + 1)'(1);
  end

  // When full, a coincident push writes the slot being popped; the head moves on in the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q       <= count_d;
      frame_error_q <= stop_bad;
      overflow_q    <= drop;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule
